// File: rtl/cache_miss_handler.sv
// Miss engine for the 4-way mp_cache: writes back a dirty victim,
// fetches the missing line, then issues one array write for the way.
//
// Ports:
//   clk, rst             clock and synchronous active-low reset
//   miss_valid/ready     fill request handshake, with miss_addr
//   victim_*             pseudo-LRU victim way and its line state
//   dfp_*                line-wide memory port (read/write/resp)
//   fill_*               array write strobe, way, set, tag and data
//   miss_done, busy      completion pulse and non-idle flag
module cache_miss_handler #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int SET_BITS    = 4,
  parameter int OFFSET_BITS = 5,
  localparam int TAG_WIDTH  =
    ADDR_WIDTH - SET_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic [1:0]            victim_way,
  input  logic                  victim_valid,
  input  logic                  victim_dirty,
  input  logic [TAG_WIDTH-1:0]  victim_tag,
  input  logic [LINE_WIDTH-1:0] victim_data,
  output logic [ADDR_WIDTH-1:0] dfp_addr,
  output logic                  dfp_read,
  output logic                  dfp_write,
  output logic [LINE_WIDTH-1:0] dfp_wdata,
  input  logic [LINE_WIDTH-1:0] dfp_rdata,
  input  logic                  dfp_resp,
  output logic                  fill_we,
  output logic [1:0]            fill_way,
  output logic [SET_BITS-1:0]   fill_set,
  output logic [TAG_WIDTH-1:0]  fill_tag,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  miss_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    READ,
    FILL,
    DONE
  } state_t;

  localparam int LINE_BITS = ADDR_WIDTH - OFFSET_BITS;

  state_t                state;
  state_t                state_n;
  logic [LINE_BITS-1:0]  line_q;
  logic [1:0]            way_q;
  logic [TAG_WIDTH-1:0]  vtag_q;
  logic [LINE_WIDTH-1:0] vdata_q;
  logic                  dirty_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic                  accept;
  logic [SET_BITS-1:0]   set_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  logic unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

  assign accept = miss_valid && (state == IDLE);
  assign set_q  = line_q[SET_BITS-1:0];
  assign tag_q  = line_q[LINE_BITS-1 -: TAG_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      line_q  <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
      dirty_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        line_q  <= miss_addr[ADDR_WIDTH-1:OFFSET_BITS];
        way_q   <= victim_way;
        vtag_q  <= victim_tag;
        vdata_q <= victim_data;
        dirty_q <= victim_valid && victim_dirty;
      end
      if (state == READ && dfp_resp) begin
        rdata_q <= dfp_rdata;
      end
    end
  end

  // Outputs decode the registered state only; dfp_resp and
  // miss_valid steer the next state, never an output.
  always_comb begin
    state_n    = state;
    miss_ready = 1'b0;
    dfp_read   = 1'b0;
    dfp_write  = 1'b0;
    dfp_addr   = '0;
    dfp_wdata  = '0;
    fill_we    = 1'b0;
    fill_data  = '0;
    miss_done  = 1'b0;
    unique case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          state_n = (victim_valid && victim_dirty)
                  ? WRITEBACK : READ;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = {vtag_q, set_q,
                     {OFFSET_BITS{1'b0}}};
        dfp_wdata = vdata_q;
        if (dfp_resp) state_n = READ;
      end
      READ: begin
        dfp_read = 1'b1;
        dfp_addr = {line_q, {OFFSET_BITS{1'b0}}};
        if (dfp_resp) state_n = FILL;
      end
      FILL: begin
        fill_we   = 1'b1;
        fill_data = rdata_q;
        state_n   = DONE;
      end
      DONE: begin
        miss_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic unused_dirty;
  assign unused_dirty = dirty_q;

  // Way/set/tag stay valid after DONE so the
  // pseudo-LRU update on the replayed hit can use them.
  assign fill_way = way_q;
  assign fill_set = set_q;
  assign fill_tag = tag_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: directed cases plus
// randomized misses against a transaction-level timing model.
module tb_cache_miss_handler;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic [1:0]   victim_way;
  logic         victim_valid;
  logic         victim_dirty;
  logic [22:0]  victim_tag;
  logic [255:0] victim_data;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         fill_we;
  logic [1:0]   fill_way;
  logic [3:0]   fill_set;
  logic [22:0]  fill_tag;
  logic [255:0] fill_data;
  logic         miss_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_miss_handler dut (
    .clk          (clk),
    .rst          (rst),
    .miss_valid   (miss_valid),
    .miss_ready   (miss_ready),
    .miss_addr    (miss_addr),
    .victim_way   (victim_way),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_data  (victim_data),
    .dfp_addr     (dfp_addr),
    .dfp_read     (dfp_read),
    .dfp_write    (dfp_write),
    .dfp_wdata    (dfp_wdata),
    .dfp_rdata    (dfp_rdata),
    .dfp_resp     (dfp_resp),
    .fill_we      (fill_we),
    .fill_way     (fill_way),
    .fill_set     (fill_set),
    .fill_tag     (fill_tag),
    .fill_data    (fill_data),
    .miss_done    (miss_done),
    .busy         (busy)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, miss_ready, 1'b1);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_rd"},    dfp_read, 1'b0);
    chk({tag, "_wr"},    dfp_write, 1'b0);
    chk({tag, "_we"},    fill_we, 1'b0);
    chk({tag, "_done"},  miss_done, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    miss_valid = 1'b1;
    dfp_resp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_idle("rst");
      chk("rst_addr", dfp_addr, 32'h0);
      chk("rst_way", fill_way, 2'd0);
      chk("rst_tag", fill_tag, 23'd0);
    end
    rst = 1'b1;
    miss_valid = 1'b0;
    dfp_resp = 1'b0;
  endtask

  // Called at a negedge in an idle cycle. Cycle c counts from
  // the cycle after the accepting edge. wl/rl: extra wait cycles
  // before each memory response. abort: reset in that cycle.
  task automatic miss(input logic [31:0] a,
                      input logic [1:0] w,
                      input logic v, input logic d,
                      input logic [22:0] vt,
                      input logic [255:0] vd,
                      input logic [255:0] rd,
                      input int wl, input int rl,
                      input bit hold, input int abort);
    int wb, rdend, fc, dc;
    logic [3:0]  s;
    logic [22:0] t;
    logic [31:0] wa, ra;
    wb    = (v && d) ? wl + 1 : 0;
    rdend = wb + rl + 1;
    fc    = rdend + 1;
    dc    = fc + 1;
    s  = 4'((a >> 5) & 32'hF);
    t  = 23'(a >> 9);
    ra = a & ~32'h1F;
    wa = (32'(vt) << 9) | (32'(s) << 5);
    miss_addr    = a;
    victim_way   = w;
    victim_valid = v;
    victim_dirty = d;
    victim_tag   = vt;
    victim_data  = vd;
    miss_valid   = 1'b1;
    chk("accept_ready", miss_ready, 1'b1);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        victim_way   = 2'($urandom);
        victim_valid = 1'($urandom);
        victim_dirty = 1'($urandom);
        victim_tag   = 23'($urandom);
        victim_data  = {8{$urandom}};
        miss_addr    = $urandom;
        miss_valid   = hold ? 1'b1 : 1'($urandom);
      end
      chk("write", dfp_write, c <= wb);
      chk("read", dfp_read, c > wb && c <= rdend);
      chk("fill_we", fill_we, c == fc);
      chk("done", miss_done, c == dc);
      chk("ready_busy", miss_ready, 1'b0);
      chk("busy", busy, 1'b1);
      if (c <= wb) begin
        chk("wb_addr", dfp_addr, wa);
        chk("wb_data", dfp_wdata, vd);
      end else if (c <= rdend) begin
        chk("rd_addr", dfp_addr, ra);
      end else if (c == fc) begin
        chk("fill_way", fill_way, w);
        chk("fill_set", fill_set, s);
        chk("fill_tag", fill_tag, t);
        chk("fill_data", fill_data, rd);
      end
      if (c == abort) begin
        rst = 1'b0;
        miss_valid = 1'b0;
        dfp_resp = 1'($urandom);
        @(negedge clk);
        rst = 1'b1;
        dfp_resp = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk_idle("post_abort");
        end
        return;
      end
      if ((wb > 0 && c == wb) || c == rdend)
        dfp_resp = 1'b1;
      else if (c >= fc)
        dfp_resp = 1'($urandom);
      else
        dfp_resp = 1'b0;
      dfp_rdata = (c == rdend) ? rd : {8{$urandom}};
    end
    @(negedge clk);
    dfp_resp = 1'b0;
    miss_valid = 1'b0;
    chk_idle("end");
    chk("keep_way", fill_way, w);
  endtask

  initial begin
    miss_valid   = 1'b0;
    miss_addr    = '0;
    victim_way   = '0;
    victim_valid = 1'b0;
    victim_dirty = 1'b0;
    victim_tag   = '0;
    victim_data  = '0;
    dfp_rdata    = '0;
    dfp_resp     = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    do_reset();
    miss(32'h0000_1234, 2'd2, 1'b0, 1'b1, 23'h55,
         {32{8'h5A}}, {32{8'hA5}}, 0, 3, 1'b0, 0);
    miss(32'h0000_0040, 2'd3, 1'b1, 1'b1, 23'h7,
         {32{8'h5A}}, {32{8'h3C}}, 2, 1, 1'b0, 0);
    miss(32'h0000_8ABC, 2'd1, 1'b1, 1'b0, 23'h7,
         {32{8'h11}}, {32{8'h22}}, 0, 0, 1'b0, 0);
    miss(32'h0000_0F00, 2'd3, 1'b0, 1'b0, 23'h1,
         {32{8'h77}}, {32{8'h88}}, 0, 2, 1'b1, 0);
    miss(32'h0001_0020, 2'd0, 1'b1, 1'b1, 23'h2,
         {32{8'h99}}, {32{8'h66}}, 0, 0, 1'b0, 0);
    miss(32'h0000_0040, 2'd3, 1'b1, 1'b1, 23'h7,
         {32{8'h5A}}, {32{8'h3C}}, 5, 1, 1'b0, 2);
    for (int n = 0; n < 60; n++) begin
      miss($urandom, 2'($urandom), 1'($urandom),
           1'($urandom), 23'($urandom),
           {8{$urandom}}, {8{$urandom}},
           $urandom_range(0, 4), $urandom_range(0, 4),
           1'($urandom),
           ($urandom_range(0, 9) == 0)
             ? $urandom_range(1, 3) : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
Miss-side engine of the 4-way, 16-set mp_cache. It consumes the pseudo-LRU victim way on a miss, writes back a dirty victim line to memory over the DFP port, fetches the missing line, and issues a single array write strobe for the chosen way. The cache then replays the access as a hit, and `fill_way` drives the pseudo-LRU update on that replay.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits (one DFP beat)
SET_BITS, 4, set index width (16 sets)
OFFSET_BITS, 5, byte offset within line
TAG_WIDTH, ADDR_WIDTH-SET_BITS-OFFSET_BITS (23), derived, not overridden

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
miss_valid  in  1  cache requests a line fill; held until accepted
miss_ready  out  1  handler idle, can accept
miss_addr  in  ADDR_WIDTH  missing address
victim_way  in  2  replacement way from pseudo-LRU (A,B,C,D = 0..3)
victim_valid  in  1  victim line valid bit
victim_dirty  in  1  victim line dirty bit
victim_tag  in  TAG_WIDTH  victim line tag
victim_data  in  LINE_WIDTH  victim line data
dfp_addr  out  ADDR_WIDTH  memory address, line-aligned
dfp_read  out  1  memory read request
dfp_write  out  1  memory write request
dfp_wdata  out  LINE_WIDTH  writeback data
dfp_rdata  in  LINE_WIDTH  fill data, valid with dfp_resp
dfp_resp  in  1  memory completion, one cycle
fill_we  out  1  one-cycle write strobe to data/tag/valid/dirty arrays
fill_way  out  2  way being written
fill_set  out  SET_BITS  set being written
fill_tag  out  TAG_WIDTH  new tag
fill_data  out  LINE_WIDTH  new line data; meaningful only while fill_we=1
miss_done  out  1  one-cycle pulse, fill complete
busy  out  1  not IDLE

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, and registered request fields are cleared.
- Outputs after reset: miss_ready=1, busy=0, dfp_read=0, dfp_write=0, fill_we=0, miss_done=0, and dfp_addr/dfp_wdata/fill_* = 0.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE the next cycle.
  - Any outstanding DFP request is dropped, and no fill_we or miss_done is issued.
  - Memory is reset concurrently.
- States: IDLE, WRITEBACK, READ, FILL, DONE.
- IDLE:
  - miss_ready=1.
  - On miss_valid&&miss_ready, latch miss_addr, victim_way, victim_tag, victim_data, and (victim_valid&&victim_dirty).
  - Next state is WRITEBACK if valid&&dirty, else READ.
  - Victim inputs are sampled only at accept; later changes are ignored.
- WRITEBACK:
  - dfp_write=1, dfp_addr={victim_tag, set, OFFSET_BITS'0}, dfp_wdata=latched victim data.
  - Held stable until dfp_resp, then go to READ.
  - dfp_write is low in the cycle after the response.
- READ:
  - dfp_read=1, dfp_addr={miss tag, set, OFFSET_BITS'0} (miss_addr offset bits forced to 0).
  - Held until dfp_resp; on dfp_resp, latch dfp_rdata and go to FILL.
- FILL:
  - fill_we=1 for exactly one cycle, with fill_way=latched victim way, fill_set=miss_addr set bits, fill_tag=miss_addr tag bits, fill_data=latched rdata.
  - Then go to DONE.
  - The array controller sets valid=1 and dirty=0 on fill_we.
- DONE: miss_done=1 for one cycle, then IDLE. miss_ready returns high in the following cycle.
- DFP rules:
  - dfp_read and dfp_write are never high together.
  - Request signals depend on registered state only.
  - dfp_resp in IDLE, FILL or DONE is ignored.
  - dfp_resp is allowed in the same cycle the request first asserts.
- miss_ready=0 in all non-IDLE states; miss_valid is ignored there.
- Latency, clean miss:
  - Accept at edge E0; dfp_read is high from cycle 1.
  - If dfp_resp arrives in cycle 1+k, fill_we is in cycle 2+k and miss_done in cycle 3+k.
- Latency, dirty miss: adds the writeback cycles plus one state transition.
- No combinational path from miss_valid or dfp_resp to any output.

Test Plan:
1. Reset: hold rst=0 two cycles with miss_valid=1 and dfp_resp=1 -> miss_ready=1, busy=0, dfp_read=dfp_write=fill_we=miss_done=0. First accept occurs on the first edge after rst=1.
2. Clean invalid victim: miss_addr=0x0000_1234, victim_way=2, victim_valid=0, dfp_resp 3 cycles after dfp_read rises, rdata=0xA5..A5.
   - Required: no dfp_write; dfp_addr=0x0000_1220.
   - fill_we one cycle with fill_way=2, fill_set=1, fill_tag=0x9, fill_data=0xA5..A5.
   - miss_done in the next cycle.
3. Dirty victim: miss_addr=0x0000_0040, victim_way=3, victim_valid=1, victim_dirty=1, victim_tag=0x7, victim_data=0x5A..5A.
   - Required: dfp_write with dfp_addr=0x0000_0E40 and wdata=0x5A..5A until resp.
   - Then dfp_read with addr 0x0000_0040; fill_way=3, fill_set=2.
   - read and write are never both high.
4. Valid clean victim: victim_valid=1, victim_dirty=0 -> goes directly to READ, no writeback.
5. Input changes while busy: after accept, change victim_way to 0 and keep miss_valid=1.
   - Required: fill_way equals the value latched at accept; miss_ready stays 0 until IDLE.
   - The second request is accepted exactly one cycle after miss_done.
6. Reset mid-writeback: assert rst=0 while dfp_write=1.
   - Required: dfp_write=0 the next cycle, no fill_we or miss_done, miss_ready=1.
